// File: rtl/sram_controller_pkg.sv
// sram_controller_pkg: constants and state encoding shared across the pipeline's memory path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_controller_pkg;

    // Controller states; the two-bit encoding is also decoded by pipeline debug logic
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO   = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // External SRAM geometry: 16-bit half-words, 18-bit half-word address
    localparam int SRAM_DW = 16;
    localparam int SRAM_AW = 18;

    // Byte address that maps to SRAM word 0; MEM_Stage uses it for its address decode too
    localparam int DMEM_BASE_ADDR = 1024;

endpackage

// File: rtl/sram_controller_if.sv
// sram_controller_if: MEM-stage word request/response bus toward the SRAM controller.
// Latency: n/a (wires only).
// Backpressure: ready low means the pipeline holds request signals stable and freezes.
interface sram_controller_if;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] data;
    logic [31:0] rdata;
    logic        ready;

    // Pipeline side issues requests and watches ready
    modport master (
        output mem_read, mem_write, address, data,
        input  rdata, ready
    );

    // Controller side services requests
    modport slave (
        input  mem_read, mem_write, address, data,
        output rdata, ready
    );

endinterface

// File: rtl/sram_controller.sv
// sram_controller: 32-bit word read/write serviced as two 16-bit async SRAM half-word accesses.
// Latency: request to ready=1 is 1 + 2*(WAIT_CYCLES+1) cycles; ready then stays high one cycle.
// Backpressure: ready drops combinationally in the request cycle and stays low until DONE.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = sram_controller_pkg::SRAM_AW
) (
    input  logic                clk,
    input  logic                rst,
    sram_controller_if.slave    bus,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
    output logic                SRAM_WE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_CE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N
);

    // Counter spans 0..WAIT_CYCLES; each phase lasts WAIT_CYCLES+1 cycles
    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    // Word index width: the half-word select supplies the SRAM address LSB
    localparam int WW = SRAM_AW - 1;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [WW-1:0] word_q, word_d;
    logic [31:0]   wdat_q, wdat_d;
    logic [31:0]   rdata_q, rdata_d;

    logic active;
    logic last;
    logic hi_phase;

    assign active   = (state_q == LO) || (state_q == HI);
    assign hi_phase = (state_q == HI);
    assign last     = (cnt_q == CW'(WAIT_CYCLES));

    // Next-state: latch the request in IDLE, walk LO then HI, capture read halves on each phase's last cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        word_d  = word_q;
        wdat_d  = wdat_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    // write wins if both are asserted
                    wr_d    = bus.mem_write;
                    word_d  = WW'((bus.address - 32'(BASE_ADDR)) >> 2);
                    wdat_d  = bus.data;
                    cnt_d   = '0;
                    state_d = LO;
                end
            end
            LO: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = HI;
                    if (!wr_q) begin
                        rdata_d[15:0] = SRAM_DQ;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HI: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (!wr_q) begin
                        rdata_d[31:16] = SRAM_DQ;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // DONE: single ready cycle, then back to IDLE regardless of the request lines
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            word_q  <= '0;
            wdat_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            word_q  <= word_d;
            wdat_q  <= wdat_d;
            rdata_q <= rdata_d;
        end
    end

    // ready: busy as soon as a request shows up in IDLE, released only in DONE
    always_comb begin
        case (state_q)
            IDLE:    bus.ready = ~(bus.mem_read | bus.mem_write);
            DONE:    bus.ready = 1'b1;
            default: bus.ready = 1'b0;
        endcase
    end

    assign bus.rdata = rdata_q;

    // Strobes derive from state only; WE_N rises on the last phase cycle so the SRAM
    // latches the write while address and data are still stable.
    assign SRAM_CE_N = ~active;
    assign SRAM_UB_N = ~active;
    assign SRAM_LB_N = ~active;
    assign SRAM_OE_N = ~(active && !wr_q);
    assign SRAM_WE_N = ~(active && wr_q && !last);
    assign SRAM_ADDR = {word_q, hi_phase};

    // Data bus driven only during write phases; otherwise released for the SRAM
    assign SRAM_DQ = (active && wr_q) ? (hi_phase ? wdat_q[31:16] : wdat_q[15:0])
                                      : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: scoreboard bench for two controllers (WAIT_CYCLES 1 and 3) on behavioural SRAMs.
// Latency: checked per request against 1 + 2*(WAIT_CYCLES+1).
// Backpressure: requests held until ready; one instance also sees a mid-access address toggle.
module tb_sram_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  rd, wr;
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic [31:0] rdata [2];
    logic        rdy [2];
    logic [17:0] sa [2];
    logic        we_n [2], oe_n [2], ce_n [2], ub_n [2], lb_n [2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int wt(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        sram_controller_if bus();
        wire  [15:0] dq;
        logic [15:0] mem [256];
        logic [17:0] last_a;
        logic        last_rd;
        logic        rd_now;
        logic [17:0] prev_sa;
        logic        prev_we;
        int          we_run;

        assign bus.mem_read  = rd[g];
        assign bus.mem_write = wr[g];
        assign bus.address   = addr[g];
        assign bus.data      = wdat[g];
        assign rdata[g]      = bus.rdata;
        assign rdy[g]        = bus.ready;

        sram_controller #(.WAIT_CYCLES((g == 0) ? 1 : 3)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .bus       (bus),
            .SRAM_ADDR (sa[g]),
            .SRAM_DQ   (dq),
            .SRAM_WE_N (we_n[g]),
            .SRAM_OE_N (oe_n[g]),
            .SRAM_CE_N (ce_n[g]),
            .SRAM_UB_N (ub_n[g]),
            .SRAM_LB_N (lb_n[g])
        );

        // SRAM model: read data valid only once address and OE have been held across one edge
        assign rd_now = !ce_n[g] && !oe_n[g];
        assign dq = rd_now ? ((last_rd && last_a == sa[g]) ? mem[sa[g][7:0]] : 16'hBAD0)
                           : 16'hzzzz;

        always @(posedge clk) begin
            last_a  <= sa[g];
            last_rd <= rd_now;
            if (rst && !ce_n[g] && !we_n[g]) mem[sa[g][7:0]] <= dq;
        end

        // WE_N pulse width and address stability around write strobes
        always @(negedge clk) begin
            if (!we_n[g]) begin
                we_run <= we_run + 1;
            end else begin
                if (we_run != 0) chk("we_pulse_len", we_run, (g == 0) ? 1 : 3);
                we_run <= 0;
            end
            if (rst && sa[g] != prev_sa) chk("we_high_at_addr_change", {31'd0, prev_we}, 32'd1);
            prev_sa <= sa[g];
            prev_we <= we_n[g];
        end
    end

    logic [31:0] exp_q [$];
    logic [31:0] shadow [int];
    logic [31:0] model_rd [2];

    // Issue one request at posedge+1, wait for ready, check latency and rdata
    task automatic op(input int i, input bit w, input bit r, input logic [31:0] a,
                      input logic [31:0] d, input bit mut);
        int n;
        logic [31:0] e;
        rd[i] = r; wr[i] = w; addr[i] = a; wdat[i] = d;
        if (w) begin
            shadow[i * 65536 + int'(a)] = d;
            exp_q.push_back(model_rd[i]);
        end else begin
            model_rd[i] = shadow.exists(i * 65536 + int'(a)) ? shadow[i * 65536 + int'(a)] : 32'h0;
            exp_q.push_back(model_rd[i]);
        end
        #1;
        chk("ready_falls_with_request", {31'd0, rdy[i]}, 32'd0);
        n = 0;
        @(negedge clk);
        while (!rdy[i] && n < 40) begin
            n++;
            if (mut && n >= 2) begin
                addr[i] = $urandom;
                wdat[i] = $urandom;
                if (n == 3) begin rd[i] = 1'b0; wr[i] = 1'b0; end
            end
            @(negedge clk);
        end
        chk("latency", n, 1 + 2 * (wt(i) + 1));
        e = exp_q.pop_front();
        chk("rdata", rdata[i], e);
        @(posedge clk);
        #1;
        rd[i] = 1'b0; wr[i] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rd = '0; wr = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdat[i] = '0; model_rd[i] = '0;
        end
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", rdata[0], 32'h0);
        chk("rst_ready", {30'd0, rdy[0], rdy[1]}, 32'd3);
        chk("rst_strobes", {27'd0, we_n[0], oe_n[0], ce_n[0], ub_n[0], lb_n[0]}, 32'h1f);
        chk("rst_addr", {14'd0, sa[0]}, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // write then read back
        op(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
        chk("mem_w0", {16'd0, gi[0].mem[0]}, 32'hBEEF);
        chk("mem_w1", {16'd0, gi[0].mem[1]}, 32'hDEAD);
        op(0, 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);

        // address mapping
        op(0, 1'b1, 1'b0, 32'd1032, 32'h12345678, 1'b0);
        chk("mem_w4", {16'd0, gi[0].mem[4]}, 32'h5678);
        chk("mem_w5", {16'd0, gi[0].mem[5]}, 32'h1234);

        // back-to-back: read issued in the cycle right after DONE
        op(0, 1'b1, 1'b0, 32'd1028, 32'h0000FFFF, 1'b0);
        op(0, 1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);

        // reset during the HI phase of a read
        rd[0] = 1'b1; addr[0] = 32'd1024;
        repeat (4) @(negedge clk);
        chk("busy_in_hi", {31'd0, rdy[0]}, 32'd0);
        rst = 1'b0; rd[0] = 1'b0; model_rd[0] = '0; model_rd[1] = '0;
        #1;
        chk("midrst_strobes", {27'd0, we_n[0], oe_n[0], ce_n[0], ub_n[0], lb_n[0]}, 32'h1f);
        chk("midrst_rdata", rdata[0], 32'h0);
        chk("midrst_ready", {31'd0, rdy[0]}, 32'd1);
        chk("midrst_addr", {14'd0, sa[0]}, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        op(0, 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);

        // read+write together: write wins, rdata untouched, mid-access toggles ignored
        op(0, 1'b1, 1'b1, 32'd1040, 32'hA5A5A5A5, 1'b1);
        chk("mem_w8", {16'd0, gi[0].mem[8]}, 32'hA5A5);
        chk("mem_w9", {16'd0, gi[0].mem[9]}, 32'hA5A5);

        // three wait states
        op(1, 1'b1, 1'b0, 32'd1024, 32'hCAFEF00D, 1'b0);
        chk("w3_mem_w0", {16'd0, gi[1].mem[0]}, 32'hF00D);
        chk("w3_mem_w1", {16'd0, gi[1].mem[1]}, 32'hCAFE);
        op(1, 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
